uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares one UART transmit line between NUM_REQ byte requesters. Arbitration is round-robin. The block generates its own bit timing from the system clock and serialises 8N1 frames (optionally 8E1). It sits between the internal byte producers (command responder, debug/log sources) and the top-level tx pin.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
SYSTEM_CLOCK_FREQ, 100000000, clock frequency in Hz
BAUD_RATE, 115200, line rate in bit/s; DIVIDER = SYSTEM_CLOCK_FREQ / BAUD_RATE (integer division), must be >= 2

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  NUM_REQ  bit i = requester i has a byte pending
req_data  input  8*NUM_REQ  byte of requester i in bits [8i+7:8i]
req_ready  output  NUM_REQ  one-hot single-cycle accept pulse to the granted requester
grant_id  output  $clog2(NUM_REQ)  index of the requester owning the current/last frame
busy  output  1  high while a frame is on the line
tx  output  1  serial line, idle high

Behaviour:
- Reset (async, immediate): tx=1, busy=0, req_ready=0, grant_id=0, state=IDLE, bit counter=0, baud counter=0, last-grant pointer=NUM_REQ-1 (first grant goes to requester 0).
- All outputs are registered.
- Requester contract: hold req_valid and req_data stable until req_ready is seen. Data is sampled only in the accept cycle. Deasserting valid before accept withdraws the request; this is legal.
- FSM states: IDLE, START, DATA, STOP (PARITY added when compiled in).
- IDLE:
  - tx=1, busy=0.
  - If any req_valid bit is set, grant the first set bit scanning from (last+1) mod NUM_REQ upward with wrap.
  - In the same cycle: register req_ready[g]=1 for exactly one cycle, grant_id=g, last=g, latch the byte into the shift register, baud counter=0, busy=1, go to START.
  - Otherwise stay in IDLE.
- Bit timing:
  - The baud counter counts 0..DIVIDER-1.
  - When it reaches DIVIDER-1 it wraps to 0 and advances the FSM.
  - Every bit therefore lasts exactly DIVIDER clocks.
  - Counter width is $clog2(DIVIDER).
- START: tx=0 for one bit time, then go to DATA with bit index=0.
- DATA: tx=shift[0], LSB first. Shift right at each bit end. After bit index 7 completes, go to STOP (or PARITY).
- STOP:
  - tx=1 for one bit time.
  - At its end: busy=0, state=IDLE.
  - Minimum one clock of IDLE (tx=1) between frames. Frame-to-frame period for back-to-back traffic is 10*DIVIDER+1 clocks (11*DIVIDER+1 with parity).
- Latency: tx falls (start bit) on the clock after req_ready is asserted, i.e. 2 clocks after req_valid is first seen in IDLE.
- Arbitration:
  - Requests arriving while busy are not accepted. They wait for the next IDLE.
  - A requester holding valid continuously is served at most once per NUM_REQ frames while others are also requesting.
  - With a single requester active, it is granted every frame.
- Simultaneous events:
  - If a new req_valid rises in the same cycle STOP ends, it is evaluated in the following IDLE cycle.
  - req_ready is never asserted outside IDLE.
- Reset mid-frame: the frame is aborted, tx returns high immediately, the granted byte is lost, the pointer is reset, and no req_ready pulse is produced.
- grant_id holds its value after the frame until the next grant.

Optional Feature:
UART_TX_ARB_PARITY_EN:
- Defined: a PARITY state is inserted between DATA and STOP. tx = XOR of the 8 data bits (even parity) for one bit time. Frame = 11 bit times.
- Undefined: no PARITY state and no parity logic. Frame = 10 bit times (8N1).

Test Plan:
- Reset: assert rst mid-DATA with SYSTEM_CLOCK_FREQ=1000000, BAUD_RATE=100000 (DIVIDER=10) -> tx=1, busy=0, req_ready=0 in the same cycle. After release, the first grant goes to requester 0.
- Single frame: req_valid=4'b0001, req_data[7:0]=8'hA5, DIVIDER=10 -> req_ready[0] pulses 1 clock. tx sequence 0,1,0,1,0,0,1,0,1,1, each held exactly 10 clocks. busy high for 100 clocks.
- Round-robin: req_valid=4'b1111 held, data 8'h11/8'h22/8'h33/8'h44 -> frames transmitted in order 0,1,2,3,0. grant_id follows. 101-clock frame period.
- Skip and wrap: last grant=2, req_valid=4'b0011 -> grant goes to 0, then 1, then 0.
- Withdrawal: req_valid[1] raised while busy and dropped before STOP ends -> requester 1 is never granted and no req_ready[1] pulse.
- Parity (UART_TX_ARB_PARITY_EN defined): byte 8'h07 -> parity bit 1. Byte 8'h03 -> parity bit 0. Frame = 110 clocks.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART transmitter among NUM_REQ byte sources.
// Define UART_TX_ARB_PARITY_EN to insert an even-parity bit (8E1 frames).
`timescale 1ns/1ps

module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ           = 4,
  parameter int unsigned SYSTEM_CLOCK_FREQ = 100000000,
  parameter int unsigned BAUD_RATE         = 115200
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       tx
);

  localparam int unsigned DIVIDER = SYSTEM_CLOCK_FREQ / BAUD_RATE;
  localparam int          ID_W    = $clog2(NUM_REQ);
  localparam int          CNT_W   = $clog2(DIVIDER);

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIVIDER - 1);
  localparam logic [ID_W-1:0]  LAST_INIT = ID_W'(NUM_REQ - 1);

`ifdef UART_TX_ARB_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t             state_q, state_n;
  logic [CNT_W-1:0]   baud_q, baud_n;
  logic [2:0]         bit_q, bit_n;
  logic [7:0]         shift_q, shift_n;
  logic               tx_q, tx_n;
  logic               busy_q, busy_n;
  logic [NUM_REQ-1:0] ready_q, ready_n;
  logic [ID_W-1:0]    grant_q, grant_n;
  logic [ID_W-1:0]    last_q, last_n;
`ifdef UART_TX_ARB_PARITY_EN
  logic               par_q, par_n;
`endif

  logic               bit_end;
  logic               found;
  logic [ID_W-1:0]    cand;
  logic [ID_W-1:0]    try_id;
  int unsigned        scan_idx;

  assign bit_end = (baud_q == BAUD_LAST);

  // Round-robin scan: first pending requester after the last grant, wrapping.
  always_comb begin
    found    = 1'b0;
    cand     = '0;
    scan_idx = 0;
    try_id   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      scan_idx = 32'(last_q) + k;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      try_id = ID_W'(scan_idx);
      if (!found && req_valid[try_id]) begin
        found = 1'b1;
        cand  = try_id;
      end
    end
  end

  // tx is registered from the current state, so the line lags the FSM by one
  // clock: the start bit appears the cycle after the accept pulse.
  always_comb begin
    state_n = state_q;
    baud_n  = bit_end ? '0 : baud_q + CNT_W'(1);
    bit_n   = bit_q;
    shift_n = shift_q;
    tx_n    = 1'b1;
    busy_n  = busy_q;
    ready_n = '0;
    grant_n = grant_q;
    last_n  = last_q;
`ifdef UART_TX_ARB_PARITY_EN
    par_n   = par_q;
`endif

    case (state_q)
      IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
        baud_n = '0;
        if (found) begin
          ready_n[cand] = 1'b1;
          grant_n       = cand;
          last_n        = cand;
          shift_n       = req_data[{cand, 3'b000} +: 8];
`ifdef UART_TX_ARB_PARITY_EN
          par_n         = ^req_data[{cand, 3'b000} +: 8];
`endif
          busy_n        = 1'b1;
          state_n       = START;
        end
      end
      START: begin
        tx_n = 1'b0;
        if (bit_end) begin
          bit_n   = '0;
          state_n = DATA;
        end
      end
      DATA: begin
        tx_n = shift_q[0];
        if (bit_end) begin
          shift_n = shift_q >> 1;
          bit_n   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_ARB_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_ARB_PARITY_EN
      PARITY: begin
        tx_n = par_q;
        if (bit_end) state_n = STOP;
      end
`endif
      STOP: begin
        tx_n = 1'b1;
        if (bit_end) begin
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: begin
        tx_n    = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ready_q <= '0;
      grant_q <= '0;
      last_q  <= LAST_INIT;
`ifdef UART_TX_ARB_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      baud_q  <= baud_n;
      bit_q   <= bit_n;
      shift_q <= shift_n;
      tx_q    <= tx_n;
      busy_q  <= busy_n;
      ready_q <= ready_n;
      grant_q <= grant_n;
      last_q  <= last_n;
`ifdef UART_TX_ARB_PARITY_EN
      par_q   <= par_n;
`endif
    end
  end

  assign tx        = tx_q;
  assign busy      = busy_q;
  assign req_ready = ready_q;
  assign grant_id  = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, scoreboard of expected
// frames, and directed round-robin / withdrawal / reset sequences.
`timescale 1ns/1ps

module tb_uart_tx_arbiter;

  localparam int D = 10;
`ifdef UART_TX_ARB_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [1:0]  grant_id;
  logic        busy;
  logic        tx;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ(4),
    .SYSTEM_CLOCK_FREQ(1000000),
    .BAUD_RATE(100000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .grant_id(grant_id),
    .busy(busy),
    .tx(tx)
  );

  typedef struct {
    logic [1:0] id;
    logic [7:0] dat;
  } exp_t;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [1:0]  exp_id;
    logic [7:0]  exp_byte;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   frames_done = 0;
  int   ready_cnt [4];
  logic mon_active = 1'b0;
  exp_t sb [$];
  int   starts [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] frame_of(input logic [7:0] b);
    logic [31:0] f;
    f      = '0;
    f[0]   = 1'b0;
    f[8:1] = b;
`ifdef UART_TX_ARB_PARITY_EN
    f[9]   = ^b;
    f[10]  = 1'b1;
`else
    f[9]   = 1'b1;
`endif
    return f;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Line monitor: detects a start bit, samples every clock of the frame.
  initial begin
    logic        prev, first, hold_bad, aborted, have;
    logic [31:0] got;
    logic [1:0]  gid;
    exp_t        e;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b1;
        mon_active = 1'b0;
      end else if (prev && !tx) begin
        mon_active = 1'b1;
        starts.push_back(cyc);
        gid  = grant_id;
        have = (sb.size() != 0);
        check("sb_nonempty_at_frame", {31'd0, have}, 32'd1);
        if (have) e = sb.pop_front();
        got = '0; hold_bad = 1'b0; aborted = 1'b0; first = 1'b0;
        for (int s = 0; s < FB*D; s++) begin
          if (s > 0) begin
            @(negedge clk);
            if (rst) begin
              aborted = 1'b1;
              break;
            end
          end
          if (s % D == 0) first = tx;
          else if (tx !== first) hold_bad = 1'b1;
          if (s % D == D/2) got[s/D] = tx;
        end
        if (!aborted) begin
          if (have) begin
            check("frame_bits", got, frame_of(e.dat));
            check("frame_grant_id", {30'd0, gid}, {30'd0, e.id});
          end
          check("bit_hold", {31'd0, hold_bad}, 32'd0);
          prev = tx;
          frames_done++;
        end else begin
          prev = 1'b1;
        end
        mon_active = 1'b0;
      end else begin
        prev = tx;
      end
    end
  end

  // Accept-pulse checker.
  initial begin
    logic [3:0] prevr;
    prevr = '0;
    for (int i = 0; i < 4; i++) ready_cnt[i] = 0;
    forever begin
      @(negedge clk);
      if (!rst && req_ready != 4'b0) begin
        check("ready_onehot", {31'd0, $onehot(req_ready)}, 32'd1);
        check("ready_with_busy", {31'd0, busy}, 32'd1);
        check("ready_single_cycle", {28'd0, prevr & req_ready}, 32'd0);
        for (int i = 0; i < 4; i++) ready_cnt[i] += int'(req_ready[i]);
      end
      prevr = req_ready;
    end
  end

  task automatic wait_ready(input int n);
    int seen;
    seen = 0;
    for (int t = 0; t < n*(FB*D+20); t++) begin
      @(negedge clk);
      if (req_ready != 4'b0) seen++;
      if (seen == n) break;
    end
    check("wait_ready", seen, n);
  endtask

  task automatic wait_done();
    logic done;
    done = 1'b0;
    for (int t = 0; t < 3*FB*D; t++) begin
      @(negedge clk);
      if (sb.size() == 0 && !mon_active && !busy && tx) begin
        done = 1'b1;
        break;
      end
    end
    check("wait_done", {31'd0, done}, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [5];
    int   bcnt, base;

    tbl[0] = '{4'b0110, 32'hDEC35A00, 2'd1, 8'h5A};
    tbl[1] = '{4'b1001, 32'h9600007E, 2'd3, 8'h96};
    tbl[2] = '{4'b1111, 32'h010203FF, 2'd0, 8'hFF};
    tbl[3] = '{4'b0100, 32'h12073456, 2'd2, 8'h07};
    tbl[4] = '{4'b1010, 32'h03008800, 2'd3, 8'h03};

    rst = 1'b1; req_valid = '0; req_data = '0;
    repeat (3) @(negedge clk);
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_ready", {28'd0, req_ready}, 32'd0);
    check("reset_grant", {30'd0, grant_id}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single frame, latency and busy length
    req_data = 32'h000000A5; req_valid = 4'b0001;
    sb.push_back('{2'd0, 8'hA5});
    @(negedge clk);
    check("latency_ready", {28'd0, req_ready}, 32'h1);
    check("latency_tx_still_idle", {31'd0, tx}, 32'd1);
    req_valid = '0;
    bcnt = 0;
    for (int t = 0; t < 2*FB*D; t++) begin
      if (!busy) break;
      bcnt++;
      if (t == 1) check("latency_tx_start", {31'd0, tx}, 32'd0);
      @(negedge clk);
    end
    check("busy_len", bcnt, FB*D);
    wait_done();

    // Table-driven single grants
    for (int i = 0; i < 5; i++) begin
      req_data = tbl[i].data; req_valid = tbl[i].valid;
      sb.push_back('{tbl[i].exp_id, tbl[i].exp_byte});
      wait_ready(1);
      check("tbl_ready", {28'd0, req_ready}, {28'd0, 4'b0001 << tbl[i].exp_id});
      req_valid = '0;
      wait_done();
    end

    // Round-robin with all requesters held
    req_data = 32'h44332211; req_valid = 4'hF;
    sb.push_back('{2'd0, 8'h11}); sb.push_back('{2'd1, 8'h22});
    sb.push_back('{2'd2, 8'h33}); sb.push_back('{2'd3, 8'h44});
    sb.push_back('{2'd0, 8'h11});
    starts.delete();
    wait_ready(5);
    req_valid = '0;
    wait_done();
    check("rr_frames", starts.size(), 5);
    for (int i = 1; i < starts.size(); i++)
      check("rr_period", starts[i] - starts[i-1], FB*D + 1);

    // Skip and wrap from last grant 2
    req_data = 32'h006C0000; req_valid = 4'b0100;
    sb.push_back('{2'd2, 8'h6C});
    wait_ready(1);
    req_valid = '0;
    wait_done();
    req_data = 32'h0000B24D; req_valid = 4'b0011;
    sb.push_back('{2'd0, 8'h4D}); sb.push_back('{2'd1, 8'hB2}); sb.push_back('{2'd0, 8'h4D});
    wait_ready(3);
    req_valid = '0;
    wait_done();

    // Withdrawal while busy
    base = ready_cnt[1];
    req_data = 32'h0000775E; req_valid = 4'b0001;
    sb.push_back('{2'd0, 8'h5E});
    wait_ready(1);
    req_valid = '0;
    repeat (20) @(negedge clk);
    req_valid = 4'b0010;
    repeat (60) @(negedge clk);
    req_valid = '0;
    wait_done();
    repeat (20) @(negedge clk);
    check("withdraw_no_ready1", ready_cnt[1], base);

    // Reset mid-DATA, then first grant back to requester 0
    req_data = 32'h009B0000; req_valid = 4'b0100;
    sb.push_back('{2'd2, 8'h9B});
    wait_ready(1);
    req_valid = '0;
    repeat (25) @(negedge clk);
    check("pre_reset_grant", {30'd0, grant_id}, 32'd2);
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("midframe_reset_tx", {31'd0, tx}, 32'd1);
    check("midframe_reset_busy", {31'd0, busy}, 32'd0);
    check("midframe_reset_ready", {28'd0, req_ready}, 32'd0);
    check("midframe_reset_grant", {30'd0, grant_id}, 32'd0);
    req_data = 32'h44332211; req_valid = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ready_in_reset", {28'd0, req_ready}, 32'd0);
    end
    rst = 1'b0;
    sb.push_back('{2'd0, 8'h11});
    wait_ready(1);
    check("post_reset_ready", {28'd0, req_ready}, 32'h1);
    req_valid = '0;
    wait_done();

    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
